// File: rtl/scc_4lc_pkg.sv
// Shared constants and types for the SCC 4LC SEC/DAEC code.
// Used by both the stream encoder and the matching decoder.
package scc_4lc_pkg;

  localparam int MSG_W = 64;
  localparam int CHK_W = 7;
  localparam int CW_W  = 71;

  localparam logic [MSG_W-1:0] H6 = 64'h144C_99EE_9671_707D;
  localparam logic [MSG_W-1:0] H5 = 64'h73AA_D511_DD69_C843;
  localparam logic [MSG_W-1:0] H4 = 64'h309B_F366_78E5_945C;
  localparam logic [MSG_W-1:0] H3 = 64'h8E2F_F9B3_3C52_CA2E;
  localparam logic [MSG_W-1:0] H2 = 64'hCCF5_FCD9_9E29_6517;
  localparam logic [MSG_W-1:0] H1 = 64'h0A76_678A_5945_C2F6;
  localparam logic [MSG_W-1:0] H0 = 64'h5519_33CD_2CA2_E1FB;

  typedef struct packed {
    logic [MSG_W-1:0] msg;
    logic [CHK_W-1:0] chk;
  } cw_t;

endpackage

// File: rtl/scc_4lc_check_gen.sv
// Combinational 64-to-7 check-bit generator for SCC 4LC.
// check[i] is the parity of the message masked by row H_i.
module scc_4lc_check_gen
  import scc_4lc_pkg::*;
(
  input  logic [MSG_W-1:0] i_msg,
  output logic [CHK_W-1:0] o_chk
);

  assign o_chk[6] = ^(i_msg & H6);
  assign o_chk[5] = ^(i_msg & H5);
  assign o_chk[4] = ^(i_msg & H4);
  assign o_chk[3] = ^(i_msg & H3);
  assign o_chk[2] = ^(i_msg & H2);
  assign o_chk[1] = ^(i_msg & H1);
  assign o_chk[0] = ^(i_msg & H0);

endmodule

// File: rtl/scc_4lc_stream_encoder.sv
// Two-stage valid/ready SCC 4LC encoder, codeword = {msg, check}.
// SCC_4LC_ERR_INJECT_EN adds a single/double-adjacent fault injector.
module scc_4lc_stream_encoder
  import scc_4lc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [MSG_W-1:0] msg_data,
  output logic             cw_valid,
  input  logic             cw_ready,
  output logic [CW_W-1:0]  cw_data,
  output logic [31:0]      enc_count
`ifdef SCC_4LC_ERR_INJECT_EN
  ,
  input  logic             inj_req,
  input  logic [6:0]       inj_pos,
  input  logic             inj_double,
  output logic             inj_armed
`endif
);

  logic             r_s1_valid;
  logic [MSG_W-1:0] r_s1_msg;
  logic             r_s2_valid;
  cw_t              r_s2_cw;
  logic [31:0]      r_cnt;

  logic             w_s2_ready;
  logic             w_s1_ready;
  logic             w_s2_load;
  logic [CHK_W-1:0] w_chk;
  logic [CW_W-1:0]  w_flip;

  assign w_s2_ready = !r_s2_valid || cw_ready;
  assign w_s1_ready = !r_s1_valid || w_s2_ready;
  assign w_s2_load  = w_s2_ready && r_s1_valid;

  assign msg_ready = w_s1_ready;
  assign cw_valid  = r_s2_valid;
  assign cw_data   = r_s2_cw;
  assign enc_count = r_cnt;

  scc_4lc_check_gen u_chk (
    .i_msg (r_s1_msg),
    .o_chk (w_chk)
  );

`ifdef SCC_4LC_ERR_INJECT_EN
  logic       r_inj_armed;
  logic [6:0] r_inj_pos;
  logic       r_inj_double;

  assign inj_armed = r_inj_armed;

  // Position 0 has no lower neighbour, so a double there flips one bit.
  always_comb begin
    w_flip = '0;
    if (r_inj_armed) begin
      w_flip = CW_W'(1) << r_inj_pos;
      if (r_inj_double && r_inj_pos != 7'd0)
        w_flip = w_flip | (CW_W'(1) << (r_inj_pos - 7'd1));
    end
  end

  // A new request in the load cycle re-arms for the following word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inj_armed  <= 1'b0;
      r_inj_pos    <= '0;
      r_inj_double <= 1'b0;
    end else begin
      if (w_s2_load)
        r_inj_armed <= 1'b0;
      if (inj_req && inj_pos <= 7'(CW_W - 1)) begin
        r_inj_armed  <= 1'b1;
        r_inj_pos    <= inj_pos;
        r_inj_double <= inj_double;
      end
    end
  end
`else
  assign w_flip = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_msg   <= '0;
    end else if (msg_valid && w_s1_ready) begin
      r_s1_valid <= 1'b1;
      r_s1_msg   <= msg_data;
    end else if (w_s2_ready) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_cw    <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid)
        r_s2_cw <= cw_t'({r_s1_msg, w_chk} ^ w_flip);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_cnt <= '0;
    else if (r_s2_valid && cw_ready && r_cnt != 32'hFFFF_FFFF)
      r_cnt <= r_cnt + 32'd1;
  end

endmodule

// File: doc/scc_4lc_stream_encoder.md
# scc_4lc_stream_encoder

Pipelined SEC/DAEC encoder for the SCC 4LC code. Maps a 64-bit message to a 71-bit codeword whose syndrome under the SCC 4LC parity-check matrix is zero, for the matching SCC 4LC decoder. Sits on the write path between a valid/ready message source and the storage/link sink. Throughput is one word per cycle with full backpressure. An optional fault-injection port produces single and double-adjacent errors so the decoder can be tested in-system.

## Interface
- Parameters: none. The code is fixed at 64 data bits, 7 check bits and 71 codeword bits.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- msg_valid  in  1  message offered.
- msg_ready  out  1  encoder accepts the message this cycle.
- msg_data  in  64  message.
- cw_valid  out  1  codeword offered.
- cw_ready  in  1  sink accepts the codeword.
- cw_data  out  71  codeword, packed as {msg_data[63:0], check[6:0]}.
- enc_count  out  32  number of codewords delivered; saturates.
- inj_req  in  1  arm a fault injection (present only with SCC_4LC_ERR_INJECT_EN).
- inj_pos  in  7  codeword bit position to flip (present only with the macro).
- inj_double  in  1  also flip position inj_pos-1 (present only with the macro).
- inj_armed  out  1  an injection is pending (present only with the macro).

## Operation
- Check bits: check[i] = ^(msg & H_i), with these row masks:
  - H6 = 64'h144C_99EE_9671_707D
  - H5 = 64'h73AA_D511_DD69_C843
  - H4 = 64'h309B_F366_78E5_945C
  - H3 = 64'h8E2F_F9B3_3C52_CA2E
  - H2 = 64'hCCF5_FCD9_9E29_6517
  - H1 = 64'h0A76_678A_5945_C2F6
  - H0 = 64'h5519_33CD_2CA2_E1FB
- Message bit k lands at codeword bit k+7.
- Stage S1 registers msg_data.
- Stage S2 computes the check bits from S1 and registers the full codeword.
- Each stage holds a valid flag.
- A stage loads when it is empty or when its content leaves in the same cycle.
- msg_ready = !s1_valid || (!s2_valid || cw_ready). This is combinational from cw_ready; no bubble is inserted under continuous flow.
- cw_valid = s2_valid. cw_data comes directly from the S2 register.
- While cw_valid=1 && cw_ready=0, cw_data and cw_valid hold stable.
- enc_count increments on each cycle with cw_valid && cw_ready. At 32'hFFFF_FFFF it holds.
- No state machine beyond the two valid flags and the injection arm flag.

## Timing
- Reset values:
  - msg_ready = 1
  - cw_valid = 0
  - cw_data = 0
  - enc_count = 0
  - inj_armed = 0
- Latency: a message accepted at edge N is presented as cw_valid from after edge N+1. It is visible the cycle after its S2 load.
- Throughput: 1 word/cycle while cw_ready=1.
- Full pipeline (both stages valid, cw_ready=0): msg_ready = 0.
- When cw_ready returns, S2 drains, S1 moves to S2 and a new message is accepted, all in the same cycle.
- Empty pipeline with msg_valid=0: no change.
- Reset mid-operation: in-flight words are discarded, the pending injection is discarded, and enc_count clears.

## Configuration
- SCC_4LC_ERR_INJECT_EN defined:
  - inj_req=1 for one cycle latches inj_pos and inj_double and sets inj_armed.
  - The next codeword loaded into S2 has bit inj_pos inverted. If inj_double=1, bit inj_pos-1 is also inverted.
  - inj_armed clears on that load.
  - inj_req while already armed overwrites the latched values.
  - inj_pos > 70 is ignored. inj_double with inj_pos = 0 flips only bit 0.
- SCC_4LC_ERR_INJECT_EN undefined: the inj_* ports and their logic are absent. Codewords are always clean.

## Structure
- Package scc_4lc_pkg holds:
  - the seven H row constants
  - widths MSG_W=64, CHK_W=7, CW_W=71
  - a codeword struct {msg, chk}
- The decoder shares this package.
- Sub-module scc_4lc_check_gen: combinational 64→7 check-bit generator, instanced in S2.

## Test plan
- msg 64'h0, cw_ready=1 → two cycles later cw_data=71'h0, enc_count=1.
- msg 64'h1 → cw_data={64'h1, 7'h65}. msg 64'h8000_0000_0000_0000 → check 7'h0C.
- 1000 random messages with random cw_ready → every delivered word has zero syndrome under H. Order is preserved, with no loss or duplication. enc_count=1000.
- Back-to-back msg_valid with cw_ready held 0 for 5 cycles → exactly 2 words accepted. msg_ready=0 until release; then 1 word/cycle.
- (SCC_4LC_ERR_INJECT_EN) inj_req with pos 70, double=0, then msg 0 → cw_data=71'h1 << 70, whose syndrome is 7'b0001100. With pos 69, double=1 → bits 69 and 68 set; the decoder reports a DAE at address 68.
- Assert rst_n low with both stages full and injection armed → next cycle cw_valid=0, inj_armed=0, enc_count=0.
